// File: rtl/mem_wait_ctrl.sv
// Word-addressed, byte-enabled memory with a configurable number of wait states.
// One request in flight; completion is a single-cycle registered ready pulse.
module mem_wait_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state_r, state_next_s;
  logic [3:0]        cnt_r, cnt_next_s;
  logic              accept_s;
  logic              we_r;
  logic [31:0]       addr_r;
  logic [3:0]        be_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic              ready_r, err_r, busy_r;
  logic              in_range_s;
  logic [ADDR_W-1:0] idx_s;
  logic [31:0]       mem [2**ADDR_W];

  // Upper address bits must be clear, otherwise the access would alias.
  assign in_range_s = (addr_r[31:ADDR_W] == {(32-ADDR_W){1'b0}});
  assign idx_s      = addr_r[ADDR_W-1:0];

  // Next-state and acceptance decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (req) begin
          accept_s     = 1'b1;
          cnt_next_s   = WAIT_LD;
          state_next_s = (WAIT_LD != 4'd0) ? WAIT : ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = WAIT;
        end
      end
      ACCESS: begin
        state_next_s = DONE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      be_r    <= 4'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_next_s == DONE);
      busy_r  <= (state_next_s != IDLE);
      if (accept_s) begin
        we_r    <= we;
        addr_r  <= addr;
        be_r    <= be;
        wdata_r <= wdata;
      end
      if (state_r == ACCESS) begin
        err_r <= ~in_range_s;
        if (!we_r) begin
          rdata_r <= in_range_s ? mem[idx_s] : 32'd0;
        end
      end
    end
  end

  // Array write on the ACCESS edge; the array itself is never reset.
  always_ff @(posedge clk) begin
    if ((state_r == ACCESS) && we_r && in_range_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_r[i]) begin
          mem[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_r;
  assign ready = ready_r;
  assign err   = err_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Randomized bench for mem_wait_ctrl: one instance with 2 wait states, one with 0,
// both checked against a word-array reference model and the spec latency rule.
module tb_mem_wait_ctrl;

  logic        clk;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [3:0]  be    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];

  logic [31:0] mdl [2][1024];
  int n_cmp = 0;
  int n_mis = 0;

  mem_wait_ctrl #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .be(be[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0])
  );

  mem_wait_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .be(be[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance d, checked against the model.
  task automatic txn(input int d, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] wd);
    int c;
    int lat;
    logic oor;
    logic [9:0] ix;
    lat = (d == 0) ? 4 : 2;
    oor = (a >= 32'd1024);
    ix  = a[9:0];
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    @(posedge clk);
    c = 0;
    do begin
      @(negedge clk);
      req[d] = 1'b0;
      c++;
      check_val("busy_in_txn", 32'(busy[d]), 32'd1);
    end while (!ready[d] && c < 20);
    check_val("latency", c, lat);
    check_val("err", 32'(err[d]), 32'(oor));
    if (!w) begin
      check_val("rdata", rdata[d], oor ? 32'd0 : mdl[d][ix]);
    end else if (!oor) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) mdl[d][ix][8*i +: 8] = wd[8*i +: 8];
      end
    end
    @(negedge clk);
    check_val("ready_pulse", 32'(ready[d]), 32'd0);
    check_val("busy_idle", 32'(busy[d]), 32'd0);
  endtask

  // Reads of 1,2,3 with req held high; bogus writes presented during WAIT.
  task automatic b2b();
    int c;
    int got;
    logic [31:0] a;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'd1; be[0] = 4'hF;
    @(posedge clk);
    got = 0; c = 0; a = 32'd1;
    while (got < 3 && c < 50) begin
      @(negedge clk);
      c++;
      check_val("b2b_busy", 32'(busy[0]), 32'd1);
      if (ready[0]) begin
        check_val("b2b_gap", c, 32'd4);
        check_val("b2b_rdata", rdata[0], mdl[0][a[9:0]]);
        check_val("b2b_err", 32'(err[0]), 32'd0);
        got++; c = 0; a = a + 32'd1;
        if (got < 3) begin
          we[0] = 1'b0; addr[0] = a;
        end else begin
          req[0] = 1'b0;
        end
      end else begin
        we[0] = 1'b1; addr[0] = 32'd5; wdata[0] = $urandom;
      end
    end
    check_val("b2b_count", got, 32'd3);
    req[0] = 1'b0;
    @(negedge clk);
    check_val("b2b_idle", 32'(busy[0]), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    int d;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; be[i] = 4'd0; wdata[i] = 32'd0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val("rst_rdata", rdata[i], 32'd0);
      check_val("rst_ready", 32'(ready[i]), 32'd0);
      check_val("rst_err", 32'(err[i]), 32'd0);
      check_val("rst_busy", 32'(busy[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) txn(i, 1'b1, 32'(j), 4'hF, $urandom | 32'd1);
    end

    txn(0, 1'b1, 32'h5, 4'hF, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h5, 4'hF, 32'd0);
    check_val("basic_read", rdata[0], 32'hDEADBEEF);

    txn(0, 1'b1, 32'h7, 4'hF, 32'h11223344);
    txn(0, 1'b1, 32'h7, 4'b0101, 32'hAABBCCDD);
    txn(0, 1'b0, 32'h7, 4'hF, 32'd0);
    check_val("partial", rdata[0], 32'h11BB33DD);

    txn(0, 1'b1, 32'h0, 4'hF, 32'd0);
    txn(0, 1'b1, 32'h400, 4'hF, 32'hFFFFFFFF);
    txn(0, 1'b0, 32'h0, 4'hF, 32'd0);
    check_val("no_alias", rdata[0], 32'd0);
    txn(0, 1'b0, 32'h7, 4'hF, 32'd0);
    txn(0, 1'b0, 32'h400, 4'hF, 32'd0);
    check_val("oor_rdata", rdata[0], 32'd0);
    check_val("oor_err_hold", 32'(err[0]), 32'd1);

    b2b();

    // Async reset while a write to 0x9 sits in WAIT.
    v = mdl[0][9];
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h9; be[0] = 4'hF; wdata[0] = ~v;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_val("arst_rdata", rdata[0], 32'd0);
    check_val("arst_ready", 32'(ready[0]), 32'd0);
    check_val("arst_busy", 32'(busy[0]), 32'd0);
    check_val("arst_err", 32'(err[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("arst_no_ready", 32'(ready[0]), 32'd0);
    end
    txn(0, 1'b0, 32'h9, 4'hF, 32'd0);
    check_val("arst_retained", rdata[0], v);

    txn(1, 1'b0, 32'h3, 4'hF, 32'd0);
    v = mdl[1][4];
    txn(1, 1'b1, 32'h4, 4'h0, ~v);
    txn(1, 1'b0, 32'h4, 4'hF, 32'd0);
    check_val("be0_unchanged", rdata[1], v);

    for (int k = 0; k < 80; k++) begin
      d = $urandom_range(1, 0);
      if ($urandom_range(7, 0) == 0) a = $urandom | 32'h0000_0400;
      else a = 32'($urandom_range(15, 0));
      txn(d, 1'($urandom_range(1, 0)), a, 4'($urandom_range(15, 0)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_wait_ctrl.md
Name: mem_wait_ctrl

Overview:
- Data/instruction memory controller that sits directly downstream of the multicycle core's memory port.
- Accepts one word-addressed, byte-enabled read or write request at a time and models a configurable number of wait states.
- Signals completion with a one-cycle ready pulse; the core's control FSM stalls on busy.
- Replaces the zero-latency memory so the core can run against slow-memory timing.

Parameters:
- ADDR_W, 10, word-index width; array depth = 2**ADDR_W words.
- WAIT_CYCLES, 2, wait states inserted before the array access (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  request strobe, sampled only when accepting (IDLE or DONE).
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  32  word address (byte address >> 2).
- be  input  4  byte enables; be[i] controls byte lane i (bits 8i+7:8i).
- wdata  input  32  write data.
- rdata  output  32  registered read data; holds until the next read completes.
- ready  output  1  one-cycle completion pulse.
- err  output  1  valid with ready; 1 = address out of range.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; rdata = 0, ready = 0, err = 0, busy = 0; wait counter = 0; captured request registers cleared.
  - Memory array is not cleared.
- States: IDLE, WAIT, ACCESS, DONE.
- Acceptance (IDLE, or DONE with req=1):
  - Capture we, addr, be, wdata.
  - Load counter = WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES > 0, otherwise go to ACCESS.
- IDLE with req=0: stay in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1 (last wait cycle), next state is ACCESS.
  - Exactly WAIT_CYCLES cycles are spent in WAIT.
- ACCESS (one cycle), range check uses the captured address:
  - In range: addr[31:ADDR_W] == 0.
  - Write, in range: at the closing edge, write each lane with be[i]=1 into mem[addr[ADDR_W-1:0]]; lanes with be[i]=0 are unchanged.
  - Write with be = 0: no change to the array; still completes normally.
  - Read, in range: rdata <= mem[addr[ADDR_W-1:0]] (full word; be ignored for reads).
  - Out of range: write dropped; read returns rdata <= 0; err set.
  - Next state is DONE.
- DONE (one cycle):
  - ready = 1; err valid.
  - Next state is IDLE, unless req=1 (back-to-back acceptance as above).
- Latency: req sampled high at the end of cycle T gives ready high in cycle T + WAIT_CYCLES + 2. With WAIT_CYCLES = 2, that is 4 cycles.
- Requests while in WAIT or ACCESS are ignored: no queueing and no error.
- err: updated only on the ACCESS→DONE edge; it holds its value outside DONE and is meaningful only while ready = 1.
- ready, err and rdata are registered (no combinational path from inputs).
- Reset mid-operation: any state returns to IDLE; a pending write not yet at its ACCESS edge is discarded and no ready is issued.
- Counter width is 4 bits; WAIT_CYCLES > 15 is illegal.

Test Plan:
- Basic write/read, WAIT_CYCLES=2:
  - Write addr=0x5, be=4'hF, wdata=0xDEADBEEF → ready 4 cycles after the req edge, err=0.
  - Then read addr=0x5 → rdata=0xDEADBEEF with ready, 4 cycles later.
- Partial write:
  - Preload 0x11223344 at addr=0x7; write be=4'b0101, wdata=0xAABBCCDD.
  - Read addr=0x7 → rdata=0x11BB33DD.
- Out of range, ADDR_W=10:
  - Write addr=0x400, wdata=0xFFFFFFFF → err=1 with ready.
  - Read addr=0x0 (previously 0) → 0, err=0 (proves no aliasing).
  - Read addr=0x400 → rdata=0, err=1.
- Busy/back-to-back:
  - Hold req=1 continuously with reads of addrs 1,2,3 presented in successive accept cycles.
  - A request presented during WAIT is ignored.
  - ready pulses are exactly WAIT_CYCLES+2 apart after the first; busy stays 1 throughout.
- WAIT_CYCLES=0:
  - Read → ready 2 cycles after the req edge.
  - Write with be=0 → array unchanged, ready still asserted.
- Async reset in WAIT:
  - Assert rst=0 mid-cycle during a write to addr=0x9 → outputs go to 0 immediately; no ready pulse.
  - After release, read 0x9 → old value retained.
